// File: rtl/mtype_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : mtype_issue_queue_if
// Description : Bundle between the scalar core, the m-type issue queue and the
//               matrix load/store and GEMM units.
// Revision    : 1.0 - initial release
// ============================================================================
interface mtype_issue_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;

    logic        ls_valid;
    logic        ls_ready;
    logic        ls_store;
    logic [4:0]  ls_mreg;
    logic [31:0] ls_addr;
    logic [31:0] ls_stride;
    logic        ls_done;

    logic        gemm_valid;
    logic        gemm_ready;
    logic [4:0]  gemm_rd;
    logic [4:0]  gemm_rs1;
    logic [4:0]  gemm_rs2;
    logic [4:0]  gemm_rs3;
    logic        gemm_done;

    logic        illegal;
    logic        idle;

    // Environment side: scalar core plus both execution units.
    modport master (
        output in_valid, in_instr, in_rs1_val, in_rs2_val,
        input  in_ready,
        input  ls_valid, ls_store, ls_mreg, ls_addr, ls_stride,
        output ls_ready, ls_done,
        input  gemm_valid, gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3,
        output gemm_ready, gemm_done,
        input  illegal, idle
    );

    // Issue queue side.
    modport slave (
        input  in_valid, in_instr, in_rs1_val, in_rs2_val,
        output in_ready,
        output ls_valid, ls_store, ls_mreg, ls_addr, ls_stride,
        input  ls_ready, ls_done,
        output gemm_valid, gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3,
        input  gemm_ready, gemm_done,
        output illegal, idle
    );
endinterface
`default_nettype wire

// File: rtl/mtype_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : mtype_issue_queue
// Description : In-order m-type instruction FIFO with matrix-register hazard
//               checks and dispatch to the load/store and GEMM units.
// Revision    : 1.0 - initial release
// ============================================================================
module mtype_issue_queue #(
    parameter int DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mtype_issue_queue_if.slave bus
);

    localparam int         c_AW    = $clog2(DEPTH);
    localparam int         c_CW    = c_AW + 1;
    localparam logic [6:0] c_OP_LD = 7'b1000011;
    localparam logic [6:0] c_OP_ST = 7'b1010011;
    localparam logic [6:0] c_OP_GM = 7'b1110011;

    // Reserved bits [31:27] are never stored.
    logic [26:0]     r_instr  [DEPTH];
    logic [31:0]     r_base   [DEPTH];
    logic [31:0]     r_stride [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;

    logic            r_ls_busy;
    logic            r_ls_st;
    logic [4:0]      r_ls_reg;
    logic            r_g_busy;
    logic [4:0]      r_g_rd;
    logic [4:0]      r_g_rs1;
    logic [4:0]      r_g_rs2;
    logic [4:0]      r_g_rs3;
    logic            r_illegal;

    function automatic logic in_wset(
        input logic [4:0] x,
        input logic       ls_busy,
        input logic       ls_st,
        input logic [4:0] ls_reg,
        input logic       g_busy,
        input logic [4:0] g_rd
    );
        return (ls_busy && !ls_st && (ls_reg == x)) || (g_busy && (g_rd == x));
    endfunction

    function automatic logic in_rset(
        input logic [4:0] x,
        input logic       ls_busy,
        input logic       ls_st,
        input logic [4:0] ls_reg,
        input logic       g_busy,
        input logic [4:0] g_rs1,
        input logic [4:0] g_rs2,
        input logic [4:0] g_rs3
    );
        return (ls_busy && ls_st && (ls_reg == x)) ||
               (g_busy && ((g_rs1 == x) || (g_rs2 == x) || (g_rs3 == x)));
    endfunction

    logic        w_unused;
    logic [26:0] w_head;
    logic [6:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rs3;
    logic        w_head_valid;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_is_gm;
    logic        w_rd_w;
    logic        w_rd_r;
    logic        w_rs1_w;
    logic        w_rs2_w;
    logic        w_rs3_w;
    logic        w_ls_ok;
    logic        w_g_ok;
    logic        w_ls_valid;
    logic        w_g_valid;
    logic        w_ls_fire;
    logic        w_g_fire;
    logic        w_full;
    logic        w_accept;
    logic        w_legal;
    logic        w_push;
    logic        w_pop;

    assign w_unused = &{1'b0, bus.in_instr[31:27]};

    assign w_head       = r_instr[r_rd_ptr];
    assign w_op         = w_head[6:0];
    assign w_rd         = w_head[11:7];
    assign w_rs1        = w_head[16:12];
    assign w_rs2        = w_head[21:17];
    assign w_rs3        = w_head[26:22];
    assign w_head_valid = (r_count != '0);
    assign w_is_ld      = (w_op == c_OP_LD);
    assign w_is_st      = (w_op == c_OP_ST);
    assign w_is_gm      = (w_op == c_OP_GM);

    assign w_rd_w  = in_wset(w_rd,  r_ls_busy, r_ls_st, r_ls_reg, r_g_busy, r_g_rd);
    assign w_rs1_w = in_wset(w_rs1, r_ls_busy, r_ls_st, r_ls_reg, r_g_busy, r_g_rd);
    assign w_rs2_w = in_wset(w_rs2, r_ls_busy, r_ls_st, r_ls_reg, r_g_busy, r_g_rd);
    assign w_rs3_w = in_wset(w_rs3, r_ls_busy, r_ls_st, r_ls_reg, r_g_busy, r_g_rd);
    assign w_rd_r  = in_rset(w_rd, r_ls_busy, r_ls_st, r_ls_reg, r_g_busy,
                             r_g_rs1, r_g_rs2, r_g_rs3);

    // Hazards only ever clear while the head waits, so valid never drops early.
    assign w_ls_ok = !r_ls_busy &&
                     ((w_is_ld && !w_rd_w && !w_rd_r) || (w_is_st && !w_rd_w));
    assign w_g_ok  = !r_g_busy && w_is_gm && !w_rs1_w && !w_rs2_w && !w_rs3_w &&
                     !w_rd_w && !w_rd_r;

    assign w_ls_valid = w_head_valid && w_ls_ok;
    assign w_g_valid  = w_head_valid && w_g_ok;
    assign w_ls_fire  = w_ls_valid && bus.ls_ready;
    assign w_g_fire   = w_g_valid && bus.gemm_ready;
    assign w_pop      = w_ls_fire || w_g_fire;

    assign w_full   = (r_count == c_CW'(DEPTH));
    assign w_accept = bus.in_valid && !w_full;
    assign w_legal  = (bus.in_instr[6:0] == c_OP_LD) || (bus.in_instr[6:0] == c_OP_ST) ||
                      (bus.in_instr[6:0] == c_OP_GM);
    assign w_push   = w_accept && w_legal;

    // Request fields read as zero while the FIFO is empty.
    assign bus.in_ready   = !w_full;
    assign bus.ls_valid   = w_ls_valid;
    assign bus.ls_store   = w_head_valid && w_is_st;
    assign bus.ls_mreg    = w_head_valid ? w_rd : 5'd0;
    assign bus.ls_addr    = w_head_valid ? r_base[r_rd_ptr] : 32'd0;
    assign bus.ls_stride  = w_head_valid ? r_stride[r_rd_ptr] : 32'd0;
    assign bus.gemm_valid = w_g_valid;
    assign bus.gemm_rd    = w_head_valid ? w_rd  : 5'd0;
    assign bus.gemm_rs1   = w_head_valid ? w_rs1 : 5'd0;
    assign bus.gemm_rs2   = w_head_valid ? w_rs2 : 5'd0;
    assign bus.gemm_rs3   = w_head_valid ? w_rs3 : 5'd0;
    assign bus.illegal    = r_illegal;
    assign bus.idle       = !w_head_valid && !r_ls_busy && !r_g_busy;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr]  <= bus.in_instr[26:0];
            r_base[r_wr_ptr]   <= bus.in_rs1_val;
            r_stride[r_wr_ptr] <= bus.in_rs2_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_ls_busy <= 1'b0;
            r_ls_st   <= 1'b0;
            r_ls_reg  <= 5'd0;
            r_g_busy  <= 1'b0;
            r_g_rd    <= 5'd0;
            r_g_rs1   <= 5'd0;
            r_g_rs2   <= 5'd0;
            r_g_rs3   <= 5'd0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A fire needs the unit idle, so a done in the same cycle is stray.
            if (w_ls_fire) begin
                r_ls_busy <= 1'b1;
                r_ls_st   <= w_is_st;
                r_ls_reg  <= w_rd;
            end else if (bus.ls_done) begin
                r_ls_busy <= 1'b0;
            end

            if (w_g_fire) begin
                r_g_busy <= 1'b1;
                r_g_rd   <= w_rd;
                r_g_rs1  <= w_rs1;
                r_g_rs2  <= w_rs2;
                r_g_rs3  <= w_rs3;
            end else if (bus.gemm_done) begin
                r_g_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mtype_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mtype_issue_queue
// Description : Directed and randomized bench for mtype_issue_queue against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtype_issue_queue;

    localparam int         DEPTH = 4;
    localparam logic [6:0] OP_LD = 7'b1000011;
    localparam logic [6:0] OP_ST = 7'b1010011;
    localparam logic [6:0] OP_GM = 7'b1110011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mtype_issue_queue_if bus ();

    mtype_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] s;
    } ent_t;

    ent_t mq[$];
    bit   m_lsb, m_lss, m_gb, m_ill;
    int   m_lsr, m_grd, m_g1, m_g2, m_g3;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    function automatic int fld(logic [31:0] w, int lo);
        return int'((w >> lo) & 32'h1f);
    endfunction

    function automatic logic [31:0] mk(logic [6:0] op, int rd, int r1, int r2, int r3);
        logic [4:0] rsv;
        rsv = 5'($urandom);
        return {rsv, 5'(r3), 5'(r2), 5'(r1), 5'(rd), op};
    endfunction

    function automatic bit in_w(int x);
        int w[$];
        if (m_lsb && !m_lss) w.push_back(m_lsr);
        if (m_gb) w.push_back(m_grd);
        foreach (w[i]) if (w[i] == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_r(int x);
        int r[$];
        if (m_lsb && m_lss) r.push_back(m_lsr);
        if (m_gb) begin
            r.push_back(m_g1);
            r.push_back(m_g2);
            r.push_back(m_g3);
        end
        foreach (r[i]) if (r[i] == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_ls_valid();
        logic [6:0] op;
        int         rd;
        if (mq.size() == 0 || m_lsb) return 1'b0;
        op = mq[0].instr[6:0];
        rd = fld(mq[0].instr, 7);
        if (op == OP_LD) return !in_w(rd) && !in_r(rd);
        if (op == OP_ST) return !in_w(rd);
        return 1'b0;
    endfunction

    function automatic bit exp_g_valid();
        logic [31:0] w;
        if (mq.size() == 0 || m_gb) return 1'b0;
        w = mq[0].instr;
        if (w[6:0] != OP_GM) return 1'b0;
        return !in_w(fld(w, 12)) && !in_w(fld(w, 17)) && !in_w(fld(w, 22)) &&
               !in_w(fld(w, 7)) && !in_r(fld(w, 7));
    endfunction

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: advances on every rising edge from the sampled inputs.
    always @(posedge clk) begin
        bit         lf, gf, acc, legal;
        ent_t       h, e;
        logic [6:0] op;
        if (rst) begin
            mq.delete();
            m_lsb = 0; m_lss = 0; m_gb = 0; m_ill = 0;
            m_lsr = 0; m_grd = 0; m_g1 = 0; m_g2 = 0; m_g3 = 0;
        end else begin
            lf    = exp_ls_valid() && bus.ls_ready;
            gf    = exp_g_valid() && bus.gemm_ready;
            acc   = bus.in_valid && (mq.size() < DEPTH);
            op    = bus.in_instr[6:0];
            legal = (op == OP_LD) || (op == OP_ST) || (op == OP_GM);
            m_ill = acc && !legal;
            if (bus.ls_done) m_lsb = 0;
            if (bus.gemm_done) m_gb = 0;
            if (lf || gf) begin
                h = mq.pop_front();
                if (lf) begin
                    m_lsb = 1;
                    m_lss = (h.instr[6:0] == OP_ST);
                    m_lsr = fld(h.instr, 7);
                end else begin
                    m_gb  = 1;
                    m_grd = fld(h.instr, 7);
                    m_g1  = fld(h.instr, 12);
                    m_g2  = fld(h.instr, 17);
                    m_g3  = fld(h.instr, 22);
                end
            end
            if (acc && legal) begin
                e.instr = bus.in_instr;
                e.a     = bus.in_rs1_val;
                e.s     = bus.in_rs2_val;
                mq.push_back(e);
            end
        end
    end

    // Compare process: every falling edge once the first reset edge has passed.
    always @(negedge clk) begin
        bit el, eg;
        if (chk_en) begin
            el = exp_ls_valid();
            eg = exp_g_valid();
            cmp("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
            cmp("idle", 32'(bus.idle), 32'(mq.size() == 0 && !m_lsb && !m_gb));
            cmp("illegal", 32'(bus.illegal), 32'(m_ill));
            cmp("ls_valid", 32'(bus.ls_valid), 32'(el));
            cmp("gemm_valid", 32'(bus.gemm_valid), 32'(eg));
            if (el) begin
                cmp("ls_store", 32'(bus.ls_store), 32'(mq[0].instr[6:0] == OP_ST));
                cmp("ls_mreg", 32'(bus.ls_mreg), 32'(fld(mq[0].instr, 7)));
                cmp("ls_addr", bus.ls_addr, mq[0].a);
                cmp("ls_stride", bus.ls_stride, mq[0].s);
            end
            if (eg) begin
                cmp("gemm_rd", 32'(bus.gemm_rd), 32'(fld(mq[0].instr, 7)));
                cmp("gemm_rs1", 32'(bus.gemm_rs1), 32'(fld(mq[0].instr, 12)));
                cmp("gemm_rs2", 32'(bus.gemm_rs2), 32'(fld(mq[0].instr, 17)));
                cmp("gemm_rs3", 32'(bus.gemm_rs3), 32'(fld(mq[0].instr, 22)));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] a, input logic [31:0] s);
        bus.in_valid   = 1'b1;
        bus.in_instr   = w;
        bus.in_rs1_val = a;
        bus.in_rs2_val = s;
    endtask

    initial begin
        logic [6:0] op;
        int         sel;
        rst = 1'b1;
        bus.in_valid = 0; bus.in_instr = 0; bus.in_rs1_val = 0; bus.in_rs2_val = 0;
        bus.ls_ready = 0; bus.ls_done = 0; bus.gemm_ready = 0; bus.gemm_done = 0;
        @(posedge clk);
        tick();
        chk_en = 1'b1;
        cmp("rst_in_ready", 32'(bus.in_ready), 32'd1);
        cmp("rst_idle", 32'(bus.idle), 32'd1);
        cmp("rst_valids", 32'({bus.ls_valid, bus.gemm_valid, bus.illegal}), 32'd0);
        cmp("rst_ls_fields", 32'({bus.ls_store, bus.ls_mreg}) | bus.ls_addr | bus.ls_stride, 32'd0);
        cmp("rst_gemm_fields", 32'({bus.gemm_rd, bus.gemm_rs1, bus.gemm_rs2, bus.gemm_rs3}), 32'd0);
        rst = 1'b0;

        // Load then dependent GEMM.
        offer(mk(OP_LD, 3, 0, 0, 0), 32'h1000, 32'd64);
        tick();
        bus.in_valid = 0;
        cmp("lit_ld_valid", 32'(bus.ls_valid), 32'd1);
        cmp("lit_ld_mreg", 32'(bus.ls_mreg), 32'd3);
        cmp("lit_ld_addr", bus.ls_addr, 32'h1000);
        cmp("lit_ld_stride", bus.ls_stride, 32'h40);
        repeat (5) begin
            tick();
            cmp("lit_ld_hold", {bus.ls_addr[15:0], bus.ls_stride[7:0], 3'd0, bus.ls_mreg},
                {16'h1000, 8'h40, 3'd0, 5'd3});
        end
        offer(mk(OP_GM, 4, 3, 0, 0), 0, 0);
        bus.ls_ready = 1;
        tick();
        bus.in_valid = 0; bus.ls_ready = 0;
        cmp("lit_gm_blocked", 32'({bus.ls_valid, bus.gemm_valid}), 32'd0);
        repeat (2) tick();
        cmp("lit_gm_blocked2", 32'(bus.gemm_valid), 32'd0);
        bus.ls_done = 1;
        tick();
        bus.ls_done = 0;
        cmp("lit_gm_after_done", 32'(bus.gemm_valid), 32'd1);
        cmp("lit_gm_regs", 32'({bus.gemm_rd, bus.gemm_rs1}), 32'({5'd4, 5'd3}));
        bus.gemm_ready = 1;
        tick();
        bus.gemm_ready = 0; bus.gemm_done = 1;
        tick();
        bus.gemm_done = 0;
        cmp("lit_idle_after_chain", 32'(bus.idle), 32'd1);

        // WAR: load into a register the in-flight GEMM still reads.
        offer(mk(OP_GM, 5, 1, 2, 5), 0, 0);
        bus.gemm_ready = 1;
        tick();
        cmp("lit_war_gm_valid", 32'(bus.gemm_valid), 32'd1);
        offer(mk(OP_LD, 2, 0, 0, 0), 32'h2000, 32'd8);
        tick();
        bus.in_valid = 0; bus.gemm_ready = 0;
        cmp("lit_war_hold", 32'(bus.ls_valid), 32'd0);
        tick();
        cmp("lit_war_hold2", 32'(bus.ls_valid), 32'd0);
        bus.gemm_done = 1;
        tick();
        bus.gemm_done = 0;
        cmp("lit_war_release", 32'({bus.ls_valid, bus.ls_mreg}), 32'({1'b1, 5'd2}));
        bus.ls_ready = 1;
        tick();
        bus.ls_ready = 0; bus.ls_done = 1;
        tick();
        bus.ls_done = 0;

        // Full FIFO, then drain with pointer wrap.
        for (int i = 0; i < 4; i++) begin
            offer(mk(OP_LD, 8 + i, 0, 0, 0), 32'(i), 32'(i + 100));
            tick();
        end
        cmp("lit_full", 32'(bus.in_ready), 32'd0);
        offer(mk(OP_LD, 12, 0, 0, 0), 32'h55, 32'h66);
        tick();
        cmp("lit_full_hold", 32'(bus.in_ready), 32'd0);
        bus.ls_ready = 1;
        tick();
        bus.ls_ready = 0;
        cmp("lit_space_after_pop", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 0;
        cmp("lit_refull", 32'(bus.in_ready), 32'd0);
        bus.ls_ready = 1; bus.ls_done = 1;
        for (int i = 0; i < 10; i++) begin
            offer(mk(OP_LD, 16 + i, 0, 0, 0), $urandom, $urandom);
            tick();
        end
        bus.in_valid = 0;
        repeat (30) tick();
        bus.ls_ready = 0; bus.ls_done = 0;
        tick();
        cmp("lit_drained", 32'(bus.idle), 32'd1);

        // Illegal opcode.
        offer(mk(7'b0110011, 1, 2, 3, 0), 0, 0);
        tick();
        bus.in_valid = 0;
        cmp("lit_illegal", 32'({bus.illegal, bus.idle, bus.in_ready}), 32'd7);
        tick();
        cmp("lit_illegal_once", 32'(bus.illegal), 32'd0);

        // Reset with queued entries and both units busy.
        bus.ls_ready = 1; bus.gemm_ready = 1;
        offer(mk(OP_LD, 1, 0, 0, 0), 0, 0);  tick();
        offer(mk(OP_GM, 2, 6, 7, 8), 0, 0);  tick();
        offer(mk(OP_LD, 9, 0, 0, 0), 0, 0);  tick();
        bus.ls_ready = 0; bus.gemm_ready = 0;
        offer(mk(OP_LD, 10, 0, 0, 0), 0, 0); tick();
        offer(mk(OP_LD, 11, 0, 0, 0), 0, 0); tick();
        bus.in_valid = 0;
        cmp("lit_busy_before_rst", 32'(bus.idle), 32'd0);
        rst = 1; bus.gemm_done = 1;
        tick();
        rst = 0; bus.gemm_done = 0;
        cmp("lit_after_rst", 32'({bus.idle, bus.ls_valid, bus.gemm_valid, bus.in_ready}), 32'b1001);
        tick();
        cmp("lit_after_rst2", 32'(bus.idle), 32'd1);

        // Enqueue, dispatch, ls_done (stray) and gemm_done in one cycle.
        bus.gemm_ready = 1;
        offer(mk(OP_GM, 20, 21, 22, 23), 0, 0); tick();
        offer(mk(OP_LD, 24, 0, 0, 0), 32'h24, 0); tick();
        bus.gemm_ready = 0;
        cmp("lit_sim_head", 32'({bus.ls_valid, bus.ls_mreg}), 32'({1'b1, 5'd24}));
        offer(mk(OP_LD, 25, 0, 0, 0), 32'h25, 0);
        bus.ls_ready = 1; bus.ls_done = 1; bus.gemm_done = 1;
        tick();
        bus.in_valid = 0; bus.ls_ready = 0; bus.ls_done = 0; bus.gemm_done = 0;
        cmp("lit_sim_state", 32'({bus.ls_valid, bus.idle, bus.in_ready}), 32'b001);
        bus.ls_done = 1;
        tick();
        bus.ls_done = 0;
        cmp("lit_sim_next", 32'({bus.ls_valid, bus.ls_mreg}), 32'({1'b1, 5'd25}));
        bus.ls_ready = 1;
        tick();
        bus.ls_ready = 0; bus.ls_done = 1;
        tick();
        bus.ls_done = 0;
        cmp("lit_sim_idle", 32'(bus.idle), 32'd1);

        // Randomized traffic with narrow register indices to provoke hazards.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 3)      op = OP_LD;
            else if (sel < 5) op = OP_ST;
            else if (sel < 9) op = OP_GM;
            else begin
                op = 7'($urandom);
                if (op == OP_LD || op == OP_ST || op == OP_GM) op = 7'b0110011;
            end
            bus.in_valid   = $urandom_range(0, 1) == 1;
            bus.in_instr   = mk(op, $urandom_range(0, 3), $urandom_range(0, 3),
                                $urandom_range(0, 3), $urandom_range(0, 3));
            bus.in_rs1_val = $urandom;
            bus.in_rs2_val = $urandom;
            bus.ls_ready   = $urandom_range(0, 2) != 0;
            bus.gemm_ready = $urandom_range(0, 2) != 0;
            bus.ls_done    = $urandom_range(0, 2) == 0;
            bus.gemm_done  = $urandom_range(0, 2) == 0;
            tick();
        end
        rst = 0; bus.in_valid = 0;
        bus.ls_ready = 1; bus.gemm_ready = 1; bus.ls_done = 1; bus.gemm_done = 1;
        repeat (30) tick();
        bus.ls_ready = 0; bus.gemm_ready = 0; bus.ls_done = 0; bus.gemm_done = 0;
        tick();
        cmp("lit_final_idle", 32'(bus.idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mtype_issue_queue.md
# mtype_issue_queue

Receiving end of the matrix (m-type) instruction stream in the tensor-core front end. The scalar core hands over LD_M / ST_M / GEMM instructions with their scalar operand values. This block buffers them in order, checks hazards against matrix registers still in flight, and dispatches each one to either the matrix load/store unit or the GEMM unit over valid/ready handshakes. Completion comes back as done pulses.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered by the scalar core.
- in_ready  out  1  space available; equals !full.
- in_instr  in  32  m-type word: reserved[31:27], rs3[26:22], rs2[21:17], rs1[16:12], rd[11:7], opcode[6:0].
- in_rs1_val  in  32  scalar base address, used by LD_M/ST_M.
- in_rs2_val  in  32  scalar row stride, used by LD_M/ST_M.
- ls_valid  out  1  load/store request valid.
- ls_ready  in  1  load/store unit accepts the request.
- ls_store  out  1  1 = ST_M, 0 = LD_M.
- ls_mreg  out  5  matrix register: destination for LD_M, source for ST_M.
- ls_addr  out  32  base address.
- ls_stride  out  32  row stride.
- ls_done  in  1  single-cycle pulse; the outstanding load/store has completed.
- gemm_valid  out  1  GEMM request valid.
- gemm_ready  in  1  GEMM unit accepts the request.
- gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3  out  5 each  computes rd = rs1×rs2 + rs3.
- gemm_done  in  1  single-cycle pulse; the outstanding GEMM has completed.
- illegal  out  1  single-cycle pulse; an accepted word had a non-m-type opcode.
- idle  out  1  FIFO empty and no operation outstanding.

## Operation
- **Enqueue** happens when in_valid && in_ready.
  - Opcode 1000011 (LD_M), 1010011 (ST_M) or 1110011 (GEMM): store {instr, rs1_val, rs2_val} at the tail.
  - Any other opcode: the word is consumed but not stored. illegal = 1 in the following cycle.
  - Reserved bits are ignored.
- **In-order dispatch.** Only the FIFO head is a dispatch candidate. At most one dispatch per cycle.
- **Per-unit tracking.** Each unit holds at most one outstanding operation. Tracked state:
  - ls_busy, ls_st, ls_reg.
  - g_busy, g_rd, g_rs1, g_rs2, g_rs3.
  - Busy is set on the dispatch handshake and cleared at the edge where the matching done is sampled.
- **Register sets.**
  - In-flight write set W = {ls_reg if ls_busy && !ls_st} ∪ {g_rd if g_busy}.
  - In-flight read set R = {ls_reg if ls_busy && ls_st} ∪ {g_rs1, g_rs2, g_rs3 if g_busy}.
- **Head is eligible** when its target unit is not busy and:
  - LD_M: rd ∉ W and rd ∉ R (WAW, WAR).
  - ST_M: rd ∉ W (RAW).
  - GEMM: rs1, rs2, rs3 ∉ W, and rd ∉ W ∪ R.
- **Valid outputs.**
  - ls_valid / gemm_valid = head valid && eligible && target matches the opcode.
  - Request fields are driven from the head entry.
  - Once asserted, valid and all fields stay stable until the ready handshake. Done pulses only remove hazards, and the head cannot change without a handshake.
- **Dispatch handshake:** pop the head and set the target unit's busy and tag registers.
- **Stray done:** ls_done or gemm_done while the matching unit is not busy is ignored.
- **Full FIFO:** in_ready = 0; no enqueue even if the head dispatches in the same cycle.
- **Simultaneous events** (enqueue, dispatch, ls_done, gemm_done in one cycle) are all honoured. Pointers and count wrap modulo DEPTH.
- **Reset mid-operation** flushes the FIFO and clears busy and tags. Unit handshakes and done pulses in progress are dropped. Done pulses sampled while RST is high are ignored.

## Timing
- **Reset values:**
  - in_ready = 1, idle = 1.
  - ls_valid = 0, gemm_valid = 0, illegal = 0.
  - ls_store, ls_mreg, ls_addr, ls_stride and all gemm_* fields = 0.
- **Enqueue latency:** a word enqueued at edge N into an empty FIFO can present valid in cycle N+1, with no bypass from in_instr.
- **Done latency:** done sampled at edge M frees the unit and clears its hazards. A dependent head can present valid in cycle M+1. The next operation to that unit cannot dispatch in cycle M.
- **Throughput:** back-to-back independent instructions alternating between units dispatch one per cycle while the targets are idle.
- **illegal** is registered and high for exactly one cycle per illegal word.
- **idle** is registered state only: !count && !ls_busy && !g_busy.

## Test plan
- **Basic load/GEMM chain:** reset, then LD_M rd=3, addr 0x1000, stride 64 → ls_valid next cycle with mreg 3, addr 0x1000, stride 0x40. Holding ls_ready=0 for 5 cycles must keep all fields stable. After ls_ready, GEMM rd=4, rs1=3 stays blocked until ls_done, then gemm_valid appears the following cycle.
- **WAR hold:** GEMM rd=5, rs1=1, rs2=2, rs3=5 in flight, then LD_M rd=2 → ls_valid stays 0 until gemm_done, then asserts one cycle later.
- **Full FIFO:** fill DEPTH=4 entries with the units stalled → in_ready = 0 and a 5th in_valid is not accepted. Dispatch one entry → in_ready = 1 the next cycle. Exercise pointer wrap over 10 entries with the order preserved.
- **Illegal opcode:** opcode 0110011 accepted → illegal pulses once, count unchanged, idle stays 1.
- **Reset mid-flight:** RST with 3 queued entries and both units busy, plus a gemm_done during RST → after reset, idle = 1, no valids asserted, and the done has no effect.
- **Simultaneous events:** in one cycle, enqueue, dispatch the head, ls_done and gemm_done → count unchanged and both busy flags reflect the new dispatch only.
